// File: rtl/bram_stream_fifo.sv
// bram_stream_fifo: first-word-fall-through FIFO over one simple-dual-port block RAM.
// Latency: a push into an empty FIFO shows o_valid three cycles later; 1 push + 1 pop per cycle sustained.
// Backpressure: o_ready is registered and drops only at full; o_data holds while o_valid && !i_ready.
//
// Ports:
//   i_clk, i_rst_n (sync, active low), i_flush (sync clear, keeps o_ready high)
//   i_valid / o_ready / i_data   : upstream write handshake
//   o_valid / i_ready / o_data   : downstream head handshake, o_data from a register
//   o_count                      : total occupancy 0..2**ADDR_WIDTH

// sdp_block_ram: one write port, one registered read port, no reset on contents.
module sdp_block_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

module bram_stream_fifo #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH:0]   o_count
);
    localparam int CAPACITY = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_n;
    logic [ADDR_WIDTH:0]   count_q, count_n;
    logic                  ready_q;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] stg0, stg1, stg0_n, stg1_n;
    logic [1:0]            stg_cnt, stg_cnt_n;
    logic [1:0]            occ;
    logic                  push, pop, issue;

    assign o_ready = ready_q;
    assign o_valid = (stg_cnt != 2'd0);
    assign o_data  = stg0;
    assign o_count = count_q;

    assign push = i_valid && ready_q;
    assign pop  = o_valid && i_ready;

    // Slots already claimed in the output stage, treating a same-cycle pop as freed.
    // stg_cnt + inflight never exceeds 2, so this cannot wrap.
    assign occ   = stg_cnt + {1'b0, inflight} - {1'b0, pop};
    // ram_cnt is registered, so a same-cycle push is never counted and a read can
    // never target the address being written this cycle.
    assign issue = (ram_cnt != '0) && (occ < 2'd2);

    assign count_n   = count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
    assign ram_cnt_n = ram_cnt + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};

    sdp_block_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (i_clk),
        .we    (push && !i_flush),
        .waddr (wptr),
        .wdata (i_data),
        .re    (issue && !i_flush),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Output stage: drop the head on pop, then append returning RAM data behind it.
    always_comb begin
        stg0_n    = stg0;
        stg1_n    = stg1;
        stg_cnt_n = stg_cnt;
        if (pop) begin
            stg0_n    = stg1;
            stg_cnt_n = stg_cnt - 2'd1;
        end
        if (inflight) begin
            if (stg_cnt_n == 2'd0) stg0_n = rd_data;
            else                   stg1_n = rd_data;
            stg_cnt_n = stg_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            count_q  <= '0;
            inflight <= 1'b0;
            stg_cnt  <= 2'd0;
            stg0     <= '0;
            stg1     <= '0;
            ready_q  <= i_rst_n;
        end else begin
            if (push)  wptr <= wptr + 1'b1;
            if (issue) rptr <= rptr + 1'b1;
            ram_cnt  <= ram_cnt_n;
            count_q  <= count_n;
            inflight <= issue;
            stg_cnt  <= stg_cnt_n;
            stg0     <= stg0_n;
            stg1     <= stg1_n;
            // count never exceeds CAPACITY, so its MSB alone means full.
            ready_q  <= !count_n[ADDR_WIDTH];
        end
    end

`ifndef SYNTHESIS
    a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        int'(o_count) <= CAPACITY);
    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (int'(o_count) == CAPACITY) |-> !(i_valid && o_ready));
    a_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_valid && !i_ready && !i_flush) |=> (o_valid && $stable(o_data)));
`endif
endmodule

// File: tb/tb_bram_stream_fifo.sv
module tb_bram_stream_fifo;
    localparam int AW = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          o_ready, o_valid;
    logic [DW-1:0] o_data;
    logic [AW:0]   o_count;

    always #5 clk = ~clk;

    bram_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (o_ready),
        .i_data  (in_data),
        .o_valid (o_valid),
        .i_ready (out_ready),
        .o_data  (o_data),
        .o_count (o_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int first_pop = -1;
    int last_pop  = -1;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle, what the next rising edge will act on.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) chk("hold", {o_valid, o_data}, {1'b1, prev_data});
            chk("count_max", 64'(o_count <= 3'd4), 64'd1);
            if (o_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h expected nothing", o_data);
                end else begin
                    chk("pop_data", o_data, exp_q.pop_front());
                end
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (in_valid && o_ready) exp_q.push_back(in_data);
            prev_stall = o_valid && !out_ready;
            prev_data  = o_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((o_count != 0 || o_valid) && n < 200) begin
            tick();
            n++;
        end
        chk({name, "_count0"}, o_count, 0);
        chk({name, "_valid0"}, o_valid, 0);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    task automatic push_n(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int pops0, c0, sent, n, seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_ready", o_ready, 0);
        rst_n = 1'b1;
        chk("rst_ready_hold", o_ready, 0);
        tick();
        chk("rst_ready_rise", o_ready, 1);

        // Latency: push 0xA5 in cycle 0, head visible in cycle 3
        in_valid = 1'b1; in_data = 32'hA5;
        tick();
        in_valid = 1'b0;
        chk("lat_c1_count", o_count, 1);
        chk("lat_c1_valid", o_valid, 0);
        tick();
        chk("lat_c2_valid", o_valid, 0);
        tick();
        chk("lat_c3_valid", o_valid, 1);
        chk("lat_c3_data", o_data, 32'hA5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_after_pop_count", o_count, 0);
        chk("lat_after_pop_valid", o_valid, 0);

        // Fill to full, fifth push ignored, then pop 1..4 in order
        pops0 = pops;
        for (int v = 1; v <= 4; v++) begin
            chk("fill_ready", o_ready, 1);
            in_valid = 1'b1; in_data = DW'(v);
            tick();
        end
        chk("full_count", o_count, 4);
        chk("full_ready", o_ready, 0);
        in_data = 32'h5;
        tick();
        tick();
        in_valid = 1'b0;
        chk("full_push_ignored", o_count, 4);
        drain("fill");
        chk("fill_pops", pops - pops0, 4);

        // Full with same-cycle push and pop: pop taken, push rejected
        push_n(32'h11, 4);
        tick(); tick(); tick();
        chk("fpp_count4", o_count, 4);
        chk("fpp_valid", o_valid, 1);
        in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("fpp_count3", o_count, 3);
        chk("fpp_ready", o_ready, 1);
        drain("fpp");

        // Streaming 0..19 with pointer wrap, one pop per cycle after 3-cycle startup
        out_ready = 1'b1;
        pops0 = pops;
        first_pop = -1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            tick();
        end
        drain("stream");
        chk("stream_pops", pops - pops0, 20);
        chk("stream_first", first_pop - c0, 3);
        chk("stream_span", last_pop - first_pop, 19);

        // Random valid/ready, 500 entries
        pops0 = pops;
        sent = 0;
        n = 0;
        while (sent < 500 && n < 20000) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            if (in_valid && o_ready) sent++;
            tick();
            n++;
        end
        chk("rand_sent", sent, 500);
        drain("rand");
        chk("rand_pops", pops - pops0, 500);

        // Flush with 3 entries and a read in flight, alongside a push of 0x77
        push_n(32'h31, 3);
        chk("flush_pre_count", o_count, 3);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h77;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", o_valid, 0);
        chk("flush_count", o_count, 0);
        chk("flush_ready", o_ready, 1);
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            tick();
            if (o_valid) seen++;
        end
        chk("flush_no_77", seen, 0);
        out_ready = 1'b0;

        // Same setup, cleared by reset instead
        push_n(32'h41, 3);
        chk("rst2_pre_count", o_count, 3);
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        chk("rst2_valid", o_valid, 0);
        chk("rst2_count", o_count, 0);
        chk("rst2_ready", o_ready, 0);
        tick();
        chk("rst2_ready_held", o_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("rst2_ready_rise", o_ready, 1);
        chk("rst2_valid_after", o_valid, 0);
        in_valid = 1'b1; in_data = 32'h5A;
        tick();
        drain("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
